// File: rtl/bike_input_loader.sv
// Byte-stream ingress stage for the BIKE decapsulation core.
// Takes one frame (h0 positions, h1 positions, c0 bytes, c1 bytes) and unpacks it
// into parallel operands. Positions are range-checked and the frame length is checked.
// A good frame launches the core with a one-cycle core_start. A bad frame is dropped
// with a one-cycle frame_err. The stream is stalled until the core reports done.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for first beat; that beat is h0 position 0
// LD_H0  | loading h0 positions, cnt = index of next byte in group
// LD_H1  | loading h1 positions
// LD_C0  | loading c0 bytes, little-endian
// LD_C1  | loading c1 bytes; final byte of frame is the last byte here
// LAUNCH | one cycle: core_start high, stream stalled
// WAIT   | operands frozen, stream stalled until core_done
module bike_input_loader #(
    parameter int R     = 127,
    parameter int W     = 5,
    parameter int POS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    output logic [W*POS_W-1:0]   h0_pos_flat,
    output logic [W*POS_W-1:0]   h1_pos_flat,
    output logic [R-1:0]         c0,
    output logic [R-1:0]         c1,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CB    = (R + 7) / 8;
    localparam int MAXG  = (W > CB) ? W : CB;
    localparam int CNT_W = (MAXG > 1) ? $clog2(MAXG) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LD_H0,
        LD_H1,
        LD_C0,
        LD_C1,
        LAUNCH,
        WAIT
    } state_t;

    state_t             state, state_nx;
    state_t             grp;
    logic [CNT_W-1:0]   cnt, cnt_nx, idx, grp_len_m1;
    logic               err, err_nx, frame_err_nx;
    logic               beat, grp_last, final_beat, in_pos_grp, pos_err, err_now;
    logic [POS_W-1:0]   pos_val;
    logic [R-1:0]       byte_mask, byte_val;

    assign in_ready   = (state != LAUNCH) && (state != WAIT);
    assign busy       = (state != IDLE);
    assign core_start = (state == LAUNCH);
    assign beat       = in_valid & in_ready;

    // IDLE behaves as h0 group at index 0, so the first beat needs no special case
    assign grp = (state == IDLE) ? LD_H0 : state;
    assign idx = (state == IDLE) ? '0 : cnt;

    assign pos_val   = in_data[POS_W-1:0];
    assign byte_mask = R'(8'hFF) << {idx, 3'b000};
    assign byte_val  = R'(in_data) << {idx, 3'b000};

    // Next-state, counter and error-flag decode
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        err_nx       = err;
        frame_err_nx = 1'b0;
        grp_len_m1   = CNT_W'(W - 1);
        if (grp == LD_C0 || grp == LD_C1) begin
            grp_len_m1 = CNT_W'(CB - 1);
        end
        grp_last   = (idx == grp_len_m1);
        final_beat = (grp == LD_C1) && grp_last;
        in_pos_grp = (grp == LD_H0) || (grp == LD_H1);
        pos_err    = in_pos_grp &&
                     (((in_data >> POS_W) != 8'd0) || (32'(pos_val) >= 32'(R)));
        // in_last must coincide with the final byte exactly
        err_now    = err | pos_err | (in_last ^ final_beat);

        case (state)
            IDLE, LD_H0, LD_H1, LD_C0, LD_C1: begin
                if (beat) begin
                    if (in_last || final_beat) begin
                        cnt_nx = '0;
                        err_nx = 1'b0;
                        if (err_now) begin
                            state_nx     = IDLE;
                            frame_err_nx = 1'b1;
                        end else begin
                            state_nx = LAUNCH;
                        end
                    end else begin
                        err_nx = err_now;
                        if (grp_last) begin
                            cnt_nx = '0;
                            case (grp)
                                LD_H0:   state_nx = LD_H1;
                                LD_H1:   state_nx = LD_C0;
                                default: state_nx = LD_C1;
                            endcase
                        end else begin
                            cnt_nx   = idx + CNT_W'(1);
                            state_nx = grp;
                        end
                    end
                end
            end
            LAUNCH: state_nx = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, counter, sticky error and frame_err pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            err       <= err_nx;
            frame_err <= frame_err_nx;
        end
    end

    // Operand registers; written only on accepted beats, so frozen in LAUNCH/WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            h0_pos_flat <= '0;
            h1_pos_flat <= '0;
            c0          <= '0;
            c1          <= '0;
        end else if (beat) begin
            case (grp)
                LD_H0: begin
                    for (int i = 0; i < W; i++) begin
                        if (idx == CNT_W'(i)) begin
                            h0_pos_flat[i*POS_W +: POS_W] <= pos_val;
                        end
                    end
                end
                LD_H1: begin
                    for (int i = 0; i < W; i++) begin
                        if (idx == CNT_W'(i)) begin
                            h1_pos_flat[i*POS_W +: POS_W] <= pos_val;
                        end
                    end
                end
                // bits shifted past R fall off, which discards the pad bits of the top byte
                LD_C0:   c0 <= (c0 & ~byte_mask) | byte_val;
                LD_C1:   c1 <= (c1 & ~byte_mask) | byte_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bike_input_loader.sv
// Testbench for bike_input_loader: randomized and directed frames, a frame-buffer
// reference model feeding a scoreboard, a monitor on core_start/frame_err, and a
// core responder that answers core_start with core_done after a programmable delay.
module tb_bike_input_loader;

    localparam int R     = 127;
    localparam int W     = 5;
    localparam int POS_W = 8;
    localparam int CB    = (R + 7) / 8;
    localparam int NB    = 2 * W + 2 * CB;

    typedef struct {
        bit                  is_err;
        logic [W*POS_W-1:0]  h0;
        logic [W*POS_W-1:0]  h1;
        logic [R-1:0]        c0;
        logic [R-1:0]        c1;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [W*POS_W-1:0]  h0_pos_flat;
    logic [W*POS_W-1:0]  h1_pos_flat;
    logic [R-1:0]        c0;
    logic [R-1:0]        c1;
    logic                core_start;
    logic                core_done;
    logic                frame_err;
    logic                busy;

    logic                done_r = 1'b0;
    logic                force_done;
    int                  done_delay;
    bit                  pend = 1'b0;
    bit                  done_prev = 1'b0;
    int                  dly = 0;
    bit                  prev_cs = 1'b0;

    int                  total = 0;
    int                  bad = 0;
    exp_t                sb[$];
    exp_t                last_launch;
    exp_t                mon_e;
    logic [7:0]          mbuf[$];
    logic [7:0]          fr[0:NB-1];
    bit                  fr_last[0:NB-1];

    assign core_done = done_r | force_done;

    always #5 clk = ~clk;

    bike_input_loader #(.R(R), .W(W), .POS_W(POS_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_last(in_last),
        .h0_pos_flat(h0_pos_flat),
        .h1_pos_flat(h1_pos_flat),
        .c0(c0),
        .c1(c1),
        .core_start(core_start),
        .core_done(core_done),
        .frame_err(frame_err),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: collect bytes until in_last or a full frame, then judge the frame
    function automatic void model_byte(input logic [7:0] d, input bit l);
        exp_t             e;
        logic [8*CB-1:0]  t0, t1;
        mbuf.push_back(d);
        if (l || mbuf.size() == NB) begin
            e.is_err = (mbuf.size() != NB) || !l;
            for (int i = 0; i < 2 * W && i < mbuf.size(); i++) begin
                if (int'(mbuf[i]) >= R) e.is_err = 1'b1;
            end
            e.h0 = '0; e.h1 = '0; t0 = '0; t1 = '0;
            if (!e.is_err) begin
                for (int i = 0; i < W; i++) begin
                    e.h0[i*8 +: 8] = mbuf[i];
                    e.h1[i*8 +: 8] = mbuf[W + i];
                end
                for (int k = 0; k < CB; k++) begin
                    t0[k*8 +: 8] = mbuf[2*W + k];
                    t1[k*8 +: 8] = mbuf[2*W + CB + k];
                end
            end
            e.c0 = t0[R-1:0];
            e.c1 = t1[R-1:0];
            sb.push_back(e);
            mbuf.delete();
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge
    task automatic send_byte(input logic [7:0] d, input bit l, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=%0d required<300", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i < hi; i++) begin
            model_byte(fr[i], fr_last[i]);
            send_byte(fr[i], fr_last[i], int'($urandom_range(maxgap, 0)));
        end
    endtask

    task automatic build_nominal();
        logic [7:0] h0v[0:W-1];
        logic [7:0] h1v[0:W-1];
        h0v = '{8'd3, 8'd17, 8'd40, 8'd77, 8'd126};
        h1v = '{8'd0, 8'd5, 8'd9, 8'd64, 8'd100};
        for (int i = 0; i < NB; i++) fr_last[i] = 1'b0;
        for (int i = 0; i < W; i++) begin
            fr[i]     = h0v[i];
            fr[W + i] = h1v[i];
        end
        for (int k = 0; k < CB; k++) begin
            fr[2*W + k]      = 8'(k);
            fr[2*W + CB + k] = ~8'(k);
        end
        fr_last[NB-1] = 1'b1;
    endtask

    task automatic build_good();
        for (int i = 0; i < NB; i++) begin
            fr[i]      = (i < 2 * W) ? 8'($urandom_range(R - 1, 0)) : 8'($urandom);
            fr_last[i] = 1'b0;
        end
        fr_last[NB-1] = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pend) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=%0d required<3000", n);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_h0"}, 128'(h0_pos_flat), 128'd0);
        chk({tag, "_h1"}, 128'(h1_pos_flat), 128'd0);
        chk({tag, "_c0"}, 128'(c0), 128'd0);
        chk({tag, "_c1"}, 128'(c1), 128'd0);
        chk({tag, "_ready"}, 128'(in_ready), 128'd1);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_start"}, 128'(core_start), 128'd0);
        chk({tag, "_ferr"}, 128'(frame_err), 128'd0);
    endtask

    // Core responder: answers core_start with core_done, checks stall and operand freeze
    always @(negedge clk) begin
        done_r = 1'b0;
        if (done_prev && !rst) chk("ready_after_done", 128'(in_ready), 128'd1);
        done_prev = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (core_start) begin
            pend = 1'b1;
            dly  = done_delay;
        end else if (pend) begin
            chk("stall_ready", 128'(in_ready), 128'd0);
            if (dly == 0) begin
                done_r    = 1'b1;
                pend      = 1'b0;
                done_prev = 1'b1;
                chk("freeze_h0", 128'(h0_pos_flat), 128'(last_launch.h0));
                chk("freeze_h1", 128'(h1_pos_flat), 128'(last_launch.h1));
                chk("freeze_c0", 128'(c0), 128'(last_launch.c0));
                chk("freeze_c1", 128'(c1), 128'(last_launch.c1));
            end else begin
                dly--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT launches or rejects a frame
    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) begin
                chk("start_width", 128'(prev_cs), 128'd0);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_start actual=1 required=0");
                end else begin
                    mon_e = sb.pop_front();
                    chk("launch_kind", 128'(mon_e.is_err), 128'd0);
                    chk("launch_h0", 128'(h0_pos_flat), 128'(mon_e.h0));
                    chk("launch_h1", 128'(h1_pos_flat), 128'(mon_e.h1));
                    chk("launch_c0", 128'(c0), 128'(mon_e.c0));
                    chk("launch_c1", 128'(c1), 128'(mon_e.c1));
                    last_launch = mon_e;
                end
            end
            if (frame_err) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame_err actual=1 required=0");
                end else begin
                    mon_e = sb.pop_front();
                    chk("err_kind", 128'(mon_e.is_err), 128'd1);
                end
            end
        end
        prev_cs = core_start;
    end

    initial begin
        int kind;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        in_last    = 1'b0;
        force_done = 1'b0;
        done_delay = 2;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // nominal frame and launch latency
        build_nominal();
        send_range(0, NB, 0);
        chk("nom_start_latency", 128'(core_start), 128'd1);
        chk("nom_h0_const", 128'(h0_pos_flat), 128'({8'd126, 8'd77, 8'd40, 8'd17, 8'd3}));
        @(negedge clk);
        chk("nom_start_off", 128'(core_start), 128'd0);
        chk("nom_wait_ready", 128'(in_ready), 128'd0);
        chk("nom_wait_busy", 128'(busy), 128'd1);
        wait_idle();

        // out-of-range position in h1
        build_nominal();
        fr[W + 2] = 8'd127;
        send_range(0, NB, 0);
        chk("range_ferr", 128'(frame_err), 128'd1);
        chk("range_nostart", 128'(core_start), 128'd0);
        @(negedge clk);
        chk("range_idle", 128'(busy), 128'd0);
        chk("range_ferr_pulse", 128'(frame_err), 128'd0);

        // early in_last: remainder of the stream forms a new (short) frame
        build_nominal();
        fr_last[19] = 1'b1;
        send_range(0, 20, 0);
        chk("early_last_ferr", 128'(frame_err), 128'd1);
        send_range(20, NB, 0);
        chk("short_frame_ferr", 128'(frame_err), 128'd1);

        // full length without in_last
        build_nominal();
        fr_last[NB-1] = 1'b0;
        send_range(0, NB, 1);
        chk("nolast_ferr", 128'(frame_err), 128'd1);
        chk("nolast_nostart", 128'(core_start), 128'd0);
        wait_idle();

        // pad-bit masking with random gaps
        build_nominal();
        fr[2*W + CB - 1] = 8'hFF;
        send_range(0, NB, 3);
        wait_idle();
        chk("mask_c0_top", 128'(c0[126:120]), 128'h7F);

        // long stall with in_valid held, then back-to-back frame
        done_delay = 50;
        build_good();
        send_range(0, NB, 0);
        build_good();
        send_range(0, NB, 0);
        done_delay = 2;
        wait_idle();

        // reset mid-frame
        build_good();
        send_range(0, 25, 1);
        rst = 1'b1;
        mbuf.delete();
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        build_good();
        send_range(0, NB, 0);
        wait_idle();

        // reset during WAIT, then core_done in IDLE must be ignored
        done_delay = 1000;
        build_good();
        send_range(0, NB, 0);
        repeat (5) @(negedge clk);
        chk("rstw_in_wait", 128'(busy), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst_wait");
        rst = 1'b0;
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        chk("idle_done_busy", 128'(busy), 128'd0);
        chk("idle_done_ready", 128'(in_ready), 128'd1);
        done_delay = 2;
        build_good();
        send_range(0, NB, 1);
        wait_idle();

        // randomized mix of good and bad frames
        for (int f = 0; f < 20; f++) begin
            kind = int'($urandom_range(3, 0));
            done_delay = int'($urandom_range(5, 0));
            build_good();
            if (kind == 1) fr[$urandom_range(2 * W - 1, 0)] = 8'($urandom_range(255, R));
            if (kind == 2) fr_last[$urandom_range(NB - 2, 0)] = 1'b1;
            if (kind == 3) fr_last[NB-1] = 1'b0;
            send_range(0, NB, 2);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
